// File: rtl/life_pkg.sv
// life_pkg: shared Game-of-Life array geometry and row-reader state encoding
package life_pkg;
  localparam int LIFE_ROWS  = 16;
  localparam int LIFE_COLS  = 16;
  localparam int LIFE_SEL_W = 4;
  typedef enum logic [1:0] {IDLE, SEL, OFFER, DONE} rdr_state_t;
endpackage

// File: rtl/life_row_reader.sv
// life_row_reader: sweeps the array row selector and streams each row out over a valid/ready handshake
module life_row_reader
  import life_pkg::*;
#(
  parameter int ROWS           = LIFE_ROWS,
  parameter int COLS           = LIFE_COLS,
  parameter int SEL_W          = LIFE_SEL_W,
  parameter bit SKIP_UNCHANGED = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [SEL_W-1:0] valo_selector,
  input  logic [COLS-1:0]  valo,
  input  logic [COLS-1:0]  valo_prev,
  output logic [COLS-1:0]  row_data,
  output logic [COLS-1:0]  row_changed,
  output logic [SEL_W-1:0] row_index,
  output logic             row_last,
  output logic             row_valid,
  input  logic             row_ready
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(ROWS - 1);
  rdr_state_t       state_q, state_d;
  logic             start_q, start_d;
  logic [SEL_W-1:0] row_q, row_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [COLS-1:0]  data_q, data_d;
  logic [COLS-1:0]  chg_q, chg_d;
  logic             skip_row;
  assign skip_row = SKIP_UNCHANGED && (valo == valo_prev) && (row_q != LAST);
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    row_d   = row_q;
    idx_d   = idx_q;
    data_d  = data_q;
    chg_d   = chg_q;
    case (state_q)
      IDLE: begin
        row_d   = '0;
        start_d = start && !abort;
        state_d = (start_q && !abort) ? SEL : IDLE;
      end
      SEL: begin
        if (skip_row) begin
          row_d = row_q + 1'b1;
        end else begin
          data_d  = valo;
          chg_d   = valo ^ valo_prev;
          idx_d   = row_q;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (row_ready) begin
          state_d = (row_q == LAST) ? DONE : SEL;
          row_d   = (row_q == LAST) ? row_q : row_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        row_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      row_d   = '0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      row_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      chg_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      chg_q   <= chg_d;
    end
  end
  assign busy          = state_q != IDLE;
  assign done          = state_q == DONE;
  assign row_valid     = state_q == OFFER;
  assign valo_selector = row_q;
  assign row_data      = data_q;
  assign row_changed   = chg_q;
  assign row_index     = idx_q;
  assign row_last      = idx_q == LAST;
endmodule

// File: tb/tb_life_row_reader.sv
// tb_life_row_reader: scoreboard bench for the row reader, array modelled as row tables
module tb_life_row_reader;
  import life_pkg::*;
  typedef logic [36:0] word_t;
  logic clk = 1'b0;
  logic reset, start, abort, start_b, row_ready, tog;
  logic ready_b, abort_b;
  logic busy, done, valid, last, busy_b, done_b, valid_b, last_b;
  logic [3:0] sel, idx, sel_b, idx_b;
  logic [15:0] data, chg, data_b, chg_b;
  logic [15:0] valo, valo_prev, valo_b, valo_prev_b;
  logic [15:0] cur[16];
  logic [15:0] prv[16];
  word_t word_a, word_bb;
  word_t q_a[$];
  word_t q_b[$];
  int cyc = 0;
  int rc, e;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  assign ready_b     = 1'b1;
  assign abort_b     = 1'b0;
  assign valo        = cur[sel];
  assign valo_prev   = prv[sel];
  assign valo_b      = cur[sel_b];
  assign valo_prev_b = prv[sel_b];
  assign word_a      = {data, chg, idx, last};
  assign word_bb     = {data_b, chg_b, idx_b, last_b};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  life_row_reader u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done),
    .valo_selector(sel), .valo(valo), .valo_prev(valo_prev), .row_data(data),
    .row_changed(chg), .row_index(idx), .row_last(last), .row_valid(valid), .row_ready(row_ready)
  );

  life_row_reader #(.SKIP_UNCHANGED(1'b1)) u_skip (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .busy(busy_b), .done(done_b),
    .valo_selector(sel_b), .valo(valo_b), .valo_prev(valo_prev_b), .row_data(data_b),
    .row_changed(chg_b), .row_index(idx_b), .row_last(last_b), .row_valid(valid_b), .row_ready(ready_b)
  );

  function automatic word_t mk(input logic [15:0] d, input logic [15:0] c, input int i);
    return {d, c, 4'(i), i == 15};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rc++;
    if (tog) row_ready = (rc % 3 == 0);
  endtask

  task automatic kick();
    start = 1'b1;
    e = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    for (n = 0; n < 400 && !done; n++) tick();
    chk(name, done, 1'b1);
  endtask

  task automatic clear_rows();
    for (int i = 0; i < 16; i++) begin
      cur[i] = 16'h0000;
      prv[i] = 16'h0000;
    end
  endtask

  task automatic push_pattern();
    for (int i = 0; i < 16; i++)
      q_a.push_back(i == 5 ? mk(16'h0000, 16'h0800, 5) :
                    i == 6 ? mk(16'h0111, 16'h0211, 6) : mk(16'h0000, 16'h0000, i));
  endtask

  task automatic monitor();
    word_t held;
    logic stall;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (valid) begin
        if (stall) chk("stall_hold", word_a, held);
        if (row_ready) begin
          if (q_a.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%h required=none", word_a);
          end else chk("word_a", word_a, q_a.pop_front());
        end
        stall = !row_ready;
        held  = word_a;
      end else stall = 1'b0;
      if (valid_b) begin
        if (q_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word_b actual=%h required=none", word_bb);
        end else chk("word_b", word_bb, q_b.pop_front());
      end
    end
  endtask

  task automatic stimulus();
    int n, dc0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; start_b = 1'b0;
    tog = 1'b0; row_ready = 1'b1; rc = 0;
    clear_rows();
    tick(); tick();
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sel", sel, 4'h0);
    chk("rst_word", word_a, 37'h0);
    reset = 1'b1;
    tick();
    // empty array, exact frame timing
    for (int i = 0; i < 16; i++) q_a.push_back(mk(16'h0000, 16'h0000, i));
    kick();
    chk("e0_busy", busy, 1'b0);
    tick();
    chk("e1_busy", busy, 1'b1);
    chk("e1_sel", sel, 4'h0);
    chk("e1_valid", valid, 1'b0);
    tick();
    chk("e2_valid", valid, 1'b1);
    wait_done("frame1_done");
    chk("done_edge", cyc - e, 33);
    tick();
    chk("done_pulse_width", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    // changed rows, ready high
    prv[5] = 16'h0800; prv[6] = 16'h0300; cur[6] = 16'h0111;
    push_pattern();
    kick();
    wait_done("frame2_done");
    tick();
    // same rows, ready 1-of-3
    tog = 1'b1;
    push_pattern();
    kick();
    wait_done("frame3_done");
    tog = 1'b0;
    row_ready = 1'b1;
    tick();
    // abort while row 7 is on offer
    for (int i = 0; i < 7; i++) q_a.push_back(mk(16'h0000, i == 5 ? 16'h0800 : i == 6 ? 16'h0211 : 16'h0000, i));
    q_a[6] = mk(16'h0111, 16'h0211, 6);
    kick();
    for (n = 0; n < 100 && !(valid && idx == 4'd7); n++) tick();
    chk("reach_row7", valid && idx == 4'd7, 1'b1);
    row_ready = 1'b0;
    abort = 1'b1;
    dc0 = done_cnt;
    tick();
    abort = 1'b0;
    chk("abort_valid", valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    tick(); tick();
    chk("abort_no_done", done_cnt, dc0);
    row_ready = 1'b1;
    push_pattern();
    kick();
    tick();
    chk("restart_sel", sel, 4'h0);
    wait_done("restart_done");
    tick();
    // asynchronous reset while row 9 is on offer
    for (int i = 0; i < 16; i++) begin
      cur[i] = 16'h1000 + 16'(i);
      prv[i] = 16'h1000 + 16'(i);
    end
    for (int i = 0; i < 9; i++) q_a.push_back(mk(16'h1000 + 16'(i), 16'h0000, i));
    kick();
    for (n = 0; n < 100 && !(valid && idx == 4'd9); n++) tick();
    chk("reach_row9", word_a, mk(16'h1009, 16'h0000, 9));
    reset = 1'b0;
    #1;
    chk("arst_valid", valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_sel", sel, 4'h0);
    chk("arst_word", word_a, 37'h0);
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) q_a.push_back(mk(16'h1000 + 16'(i), 16'h0000, i));
    kick();
    wait_done("post_reset_done");
    tick();
    // skip-unchanged reader, vertical-to-horizontal blinker
    clear_rows();
    prv[4] = 16'h0020; prv[5] = 16'h0020; prv[6] = 16'h0020; cur[5] = 16'h0070;
    q_b.push_back(mk(16'h0000, 16'h0020, 4));
    q_b.push_back(mk(16'h0070, 16'h0050, 5));
    q_b.push_back(mk(16'h0000, 16'h0020, 6));
    q_b.push_back(mk(16'h0000, 16'h0000, 15));
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (n = 0; n < 200 && !done_b; n++) tick();
    chk("skip_done", done_b, 1'b1);
    tick(); tick();
    chk("q_a_empty", q_a.size(), 0);
    chk("q_b_empty", q_b.size(), 0);
    chk("done_count", done_cnt, 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
  end
endmodule
